// File: rtl/stdp_learning_pkg.sv
// Shared types and helpers for the STDP learning engine.
// Holds the FSM state enum, saturating add and flat-slice indexing.
package stdp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    TRACE
  } state_t;

  // Symmetric saturation: the most-negative code is never produced.
  function automatic int sat_add(
    input int w,
    input int delta,
    input int wb
  );
    int sum;
    int lim;
    sum = w + delta;
    lim = (1 << (wb - 1)) - 1;
    if (sum > lim)
      return lim;
    if (sum < -lim)
      return -lim;
    return sum;
  endfunction

  // LSB position of w[i][j] inside weights_flat.
  function automatic int widx(
    input int i,
    input int j,
    input int n,
    input int wb
  );
    return (i * n + j) * wb;
  endfunction

endpackage

// File: rtl/stdp_learning_if.sv
// Spike vector valid/ready handshake.
// The neuron array is the master; the learning engine is the slave.
interface stdp_learning_if #(
  parameter int N = 8
) ();
  logic         spike_valid;
  logic [N-1:0] spikes;
  logic         spike_ready;

  modport master (
    output spike_valid,
    output spikes,
    input  spike_ready
  );

  modport slave (
    input  spike_valid,
    input  spikes,
    output spike_ready
  );
endinterface

// File: rtl/stdp_learning_trace_bank.sv
// Per-neuron saturating eligibility traces.
// One strobe reloads spiking neurons and decays all the others.
module stdp_trace_bank #(
  parameter int N         = 8,
  parameter int TRACE_W   = 4,
  parameter int TRACE_MAX = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step,
  input  logic [N-1:0] spk,
  output logic [N-1:0] nz
);

  logic [TRACE_W-1:0] tr [N];

  // Parallel load on spike, otherwise decrement toward zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++)
        tr[k] <= '0;
    end else if (step) begin
      for (int k = 0; k < N; k++) begin
        if (spk[k])
          tr[k] <= TRACE_W'(TRACE_MAX);
        else if (tr[k] != '0)
          tr[k] <= tr[k] - TRACE_W'(1);
      end
    end
  end

  // Only "trace is live" matters to the weight update.
  always_comb begin
    nz = '0;
    for (int k = 0; k < N; k++)
      nz[k] = (tr[k] != '0);
  end

endmodule

// File: rtl/stdp_learning.sv
// STDP learning engine: per-event N*N pair scan with LTP and LTD.
// Weights are signed, symmetric-saturating and exposed flat.
module stdp_learning
  import stdp_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = 8,
  parameter int TRACE_W   = 4,
  parameter int TRACE_MAX = 3,
  parameter int LTP_STEP  = 2,
  parameter int LTD_STEP  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               learning_enable,
  input  logic               weight_clear,
  stdp_learning_if.slave     spk,
  output logic               busy,
  output logic               done,
  output logic [N*N*W-1:0]   weights_flat
);

  localparam int IW = $clog2(N);
  localparam int KW = $clog2(N * N);

  state_t         st;
  state_t         st_n;
  logic [N-1:0]   spk_q;
  logic [IW-1:0]  i_q;
  logic [IW-1:0]  j_q;
  logic [W-1:0]   wmem [N*N];
  logic [N-1:0]   nz;

  logic           accept;
  logic           clr;
  logic           trace_step;
  logic           last;
  logic [KW-1:0]  k;
  logic           ltp;
  logic           ltd;
  int             dlt;
  logic [W-1:0]   w_new;
  logic           we;

  assign spk.spike_ready = (st == IDLE);
  assign busy            = (st != IDLE);
  assign last = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      st <= IDLE;
    else
      st <= st_n;
  end

  // Next state and control strobes; clear beats a pending event.
  always_comb begin
    st_n       = st;
    accept     = 1'b0;
    clr        = 1'b0;
    trace_step = 1'b0;
    done       = 1'b0;
    unique case (st)
      IDLE: begin
        if (weight_clear) begin
          clr = 1'b1;
        end else if (spk.spike_valid) begin
          accept = 1'b1;
          st_n   = SCAN;
        end
      end
      SCAN: begin
        if (last)
          st_n = TRACE;
      end
      TRACE: begin
        trace_step = 1'b1;
        done       = 1'b1;
        st_n       = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  // Event latch and pair counters, wrapped at N-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spk_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
    end else if (accept) begin
      spk_q <= spk.spikes;
      i_q   <= '0;
      j_q   <= '0;
    end else if (st == SCAN) begin
      if (j_q == IW'(N - 1)) begin
        j_q <= '0;
        i_q <= (i_q == IW'(N - 1)) ? '0 : i_q + IW'(1);
      end else begin
        j_q <= j_q + IW'(1);
      end
    end
  end

  stdp_trace_bank #(
    .N         (N),
    .TRACE_W   (TRACE_W),
    .TRACE_MAX (TRACE_MAX)
  ) u_trace (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (trace_step),
    .spk     (spk_q),
    .nz      (nz)
  );

  // Current pair's delta and saturated result; traces are pre-event.
  always_comb begin
    k     = KW'(i_q) * KW'(N) + KW'(j_q);
    ltp   = spk_q[i_q] && nz[j_q];
    ltd   = spk_q[j_q] && nz[i_q];
    dlt   = (ltp ? LTP_STEP : 0) - (ltd ? LTD_STEP : 0);
    w_new = W'(sat_add(int'($signed(wmem[k])), dlt, W));
    we    = (st == SCAN) && learning_enable && (i_q != j_q);
  end

  // Weight matrix: clear in IDLE, one pair written per SCAN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < N * N; n++)
        wmem[n] <= '0;
    end else if (clr) begin
      for (int n = 0; n < N * N; n++)
        wmem[n] <= '0;
    end else if (we) begin
      wmem[k] <= w_new;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_i
    for (genvar gj = 0; gj < N; gj++) begin : g_j
      localparam int B = widx(gi, gj, N, W);
      assign weights_flat[B +: W] = wmem[gi*N+gj];
    end
  end

endmodule

// File: tb/tb_stdp_learning.sv
// Self-checking bench for stdp_learning (N=4, W=8).
// Directed event sequences plus random don't-care spikes vs. a model.
module tb_stdp_learning;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         learning_enable = 1'b1;
  logic         weight_clear = 1'b0;
  logic         busy;
  logic         done;
  logic [127:0] weights_flat;

  int checks = 0;
  int errors = 0;

  int mw [N][N];
  int mt [N];

  stdp_learning_if #(.N(N)) ifc ();

  stdp_learning #(
    .N         (N),
    .W         (W),
    .TRACE_W   (4),
    .TRACE_MAX (3),
    .LTP_STEP  (2),
    .LTD_STEP  (1)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .learning_enable (learning_enable),
    .weight_clear    (weight_clear),
    .spk             (ifc),
    .busy            (busy),
    .done            (done),
    .weights_flat    (weights_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mflat();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(i*N+j)*W +: W] = 8'(mw[i][j]);
    return r;
  endfunction

  function automatic logic [7:0] wslice(input int i, input int j);
    return weights_flat[(i*N+j)*W +: W];
  endfunction

  task automatic model_reset(input bit traces);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++)
        mw[i][j] = 0;
      if (traces)
        mt[i] = 0;
    end
  endtask

  // Reference: post i potentiates on spike after a live pre trace,
  // depresses when pre j spikes after a live post trace.
  task automatic model_event(input logic [3:0] s, input bit en);
    int v;
    if (en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (i != j) begin
            v = mw[i][j];
            if (s[i] && mt[j] != 0) v += 2;
            if (s[j] && mt[i] != 0) v -= 1;
            if (v > 127) v = 127;
            if (v < -127) v = -127;
            mw[i][j] = v;
          end
    end
    for (int n = 0; n < N; n++)
      mt[n] = s[n] ? 3 : (mt[n] > 0 ? mt[n] - 1 : 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic send_event(input logic [3:0] s, input bit en,
                            input bit clr_mid);
    int n;
    @(negedge clk);
    learning_enable = en;
    ifc.spike_valid = 1'b1;
    ifc.spikes = s;
    n = 0;
    while (!ifc.spike_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    ifc.spike_valid = 1'b0;
    ifc.spikes = 4'($urandom);
    if (clr_mid) weight_clear = 1'b1;
    chk("busy_scan", busy, 1'b1);
    wait_done(n);
    weight_clear = 1'b0;
    chk("done_latency", n, N * N);
    model_event(s, en);
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);
    chk("ready_back", ifc.spike_ready, 1'b1);
    chk("weights", weights_flat, mflat());
  endtask

  task automatic clear_idle();
    @(negedge clk);
    weight_clear = 1'b1;
    @(posedge clk); #1;
    weight_clear = 1'b0;
    model_reset(1'b0);
    chk("clear_idle", weights_flat, '0);
  endtask

  task automatic expire();
    repeat (4) send_event(4'b0000, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    ifc.spike_valid = 1'b0;
    ifc.spikes = '0;
    model_reset(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_weights", weights_flat, '0);
    chk("rst_ready", ifc.spike_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-scan.
    send_event(4'b0011, 1'b1, 1'b0);
    @(negedge clk);
    ifc.spike_valid = 1'b1;
    ifc.spikes = 4'b0011;
    @(posedge clk); #1;
    ifc.spike_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    model_event(4'b0011, 1'b1);
    chk("partial_scan", weights_flat, mflat());
    #2 reset_n = 1'b0;
    #1;
    model_reset(1'b1);
    chk("midscan_rst_w", weights_flat, '0);
    chk("midscan_rst_rdy", ifc.spike_ready, 1'b1);
    chk("midscan_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Pair ordering.
    send_event(4'b0001, 1'b1, 1'b0);
    send_event(4'b0010, 1'b1, 1'b0);
    chk("order_w10", wslice(1, 0), 8'h02);
    chk("order_w01", wslice(0, 1), 8'hFF);

    // Trace decay: two gaps keep it alive, three expire it.
    clear_idle();
    expire();
    send_event(4'b0001, 1'b1, 1'b0);
    repeat (2) send_event(4'b0000, 1'b1, 1'b0);
    send_event(4'b0010, 1'b1, 1'b0);
    chk("decay2_w10", wslice(1, 0), 8'h02);
    clear_idle();
    expire();
    send_event(4'b0001, 1'b1, 1'b0);
    repeat (3) send_event(4'b0000, 1'b1, 1'b0);
    send_event(4'b0010, 1'b1, 1'b0);
    chk("decay3_w10", wslice(1, 0), 8'h00);

    // Simultaneous spikes.
    clear_idle();
    expire();
    send_event(4'b0011, 1'b1, 1'b0);
    send_event(4'b0011, 1'b1, 1'b0);
    chk("simul_w01", wslice(0, 1), 8'h01);
    chk("simul_w10", wslice(1, 0), 8'h01);
    chk("simul_diag", {wslice(0, 0), wslice(1, 1)}, 16'h0000);

    // Random events, random enable.
    for (int e = 0; e < 20; e++)
      send_event(4'($urandom), 1'($urandom), 1'b0);

    // Positive saturation.
    clear_idle();
    expire();
    for (int e = 0; e < 150; e++) begin
      send_event(4'b0001, 1'b1, 1'b0);
      send_event(4'b0010, 1'b1, 1'b0);
    end
    chk("sat_pos", wslice(1, 0), 8'h7F);

    // Negative saturation, LTD only on w[1][0].
    for (int e = 0; e < 260; e++) begin
      send_event(4'b0010, 1'b0, 1'b0);
      send_event(4'b0001, 1'b1, 1'b0);
    end
    chk("sat_neg", wslice(1, 0), 8'h81);

    // Frozen weights while traces keep evolving.
    send_event(4'b0001, 1'b0, 1'b0);
    send_event(4'b0010, 1'b0, 1'b0);
    send_event(4'b0001, 1'b1, 1'b0);

    // Clear during scan is ignored.
    send_event(4'b0010, 1'b1, 1'b1);
    chk("clr_scan_nz", weights_flat != '0, 1'b1);

    // Clear wins over a pending event, which is then accepted.
    @(negedge clk);
    weight_clear = 1'b1;
    ifc.spike_valid = 1'b1;
    ifc.spikes = 4'b0001;
    @(posedge clk); #1;
    model_reset(1'b0);
    chk("clr_win_busy", busy, 1'b0);
    chk("clr_win_w", weights_flat, '0);
    weight_clear = 1'b0;
    @(posedge clk); #1;
    ifc.spike_valid = 1'b0;
    chk("pending_acc", busy, 1'b1);
    wait_done(n);
    chk("pending_done", n, N * N);
    model_event(4'b0001, 1'b1);
    @(posedge clk); #1;
    chk("pending_w", weights_flat, mflat());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
